// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode and FSM state encodings shared by the universal shift register
package shift_reg_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one single-bit shift/rotate step plus the bit that leaves the register
module shift_step import shift_reg_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             out_o
);
  always_comb begin
    q_o = q_i;
    out_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        q_o = {q_i[WIDTH-2:0], sin_i};
        out_o = q_i[WIDTH-1];
      end
      MODE_SHR: begin
        q_o = {sin_i, q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      MODE_ROTL: begin
        q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        out_o = q_i[WIDTH-1];
      end
      MODE_ROTR: begin
        q_o = {q_i[0], q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      MODE_ASR: begin
        q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      default: begin
        q_o = q_i;
        out_o = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal register with preset, load and multi-cycle shift/rotate handshake
module shift_reg_univ import shift_reg_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  state_t state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0] mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d, step_q;
  logic sout_q, sout_d, step_out, accept, quick;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i(q_q), .mode_i(mode_q), .sin_i(sin), .q_o(step_q), .out_o(step_out)
  );
  assign accept = start && state_q != ST_RUN;
  // LOAD, HOLD, reserved and zero-length shifts finish on the start edge itself
  assign quick = mode inside {MODE_HOLD, MODE_LOAD, MODE_RSVD} || amount == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      mode_q <= MODE_HOLD;
      q_q <= '0;
      sout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      q_q <= q_d;
      sout_q <= sout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    q_d = q_q;
    sout_d = sout_q;
    if (set) begin
      state_d = ST_IDLE;
      cnt_d = '0;
      q_d = '1;
      sout_d = 1'b0;
    end else if (accept) begin
      mode_d = mode;
      cnt_d = amount;
      q_d = mode == MODE_LOAD ? d : q_q;
      state_d = quick ? ST_DONE : ST_RUN;
    end else if (state_q == ST_RUN) begin
      q_d = step_q;
      sout_d = step_out;
      cnt_d = cnt_q - AMT_W'(1);
      state_d = cnt_q == AMT_W'(1) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end
  always_comb begin
    busy = state_q == ST_RUN;
    done = state_q == ST_DONE;
    q = q_q;
    qbar = ~q_q;
    sout = sout_q;
  end
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: scoreboard bench with an arithmetic reference model for shift_reg_univ
module tb_shift_reg_univ;
  localparam int W = 8;
  localparam int AW = 4;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
  localparam logic [2:0] ROTL = 3'd4, ROTR = 3'd5, ASR = 3'd6, RSVD = 3'd7;
  logic clk = 1'b0, reset = 1'b0, set = 1'b0, start = 1'b0, sin = 1'b0;
  logic [2:0] mode = '0;
  logic [AW-1:0] amount = '0;
  logic [W-1:0] d = '0, q, qbar;
  logic sout, busy, done;
  int tests = 0, fails = 0;
  typedef struct {logic [W-1:0] q; logic s; logic dn;} ent_t;
  ent_t sb[$];
  logic [W-1:0] m_q = '0;
  logic m_sout = 1'b0;
  shift_reg_univ #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .set(set), .start(start), .mode(mode), .amount(amount),
    .d(d), .sin(sin), .q(q), .qbar(qbar), .sout(sout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one literal step computed arithmetically: {bit_out, next_value}
  function automatic logic [W:0] model_step(input logic [2:0] m, input logic [W-1:0] v, input logic s);
    int x, nq, o;
    x = int'(v);
    nq = x;
    o = 0;
    case (m)
      SHL:  begin nq = (x * 2 + int'(s)) % 256; o = x / 128; end
      SHR:  begin nq = x / 2 + int'(s) * 128;   o = x % 2;   end
      ROTL: begin nq = (x * 2) % 256 + x / 128; o = x / 128; end
      ROTR: begin nq = x / 2 + (x % 2) * 128;   o = x % 2;   end
      ASR:  begin nq = x / 2 + (x / 128) * 128; o = x % 2;   end
      default: begin nq = x; o = 0; end
    endcase
    return {o[0], nq[W-1:0]};
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy_and_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (busy || done) begin
        if (sb.size() == 0) begin
          chk("unexpected_busy_or_done", {30'd0, busy, done}, 32'd0);
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("q", {24'd0, q}, {24'd0, e.q});
          chk("qbar", {24'd0, qbar}, {24'd0, ~e.q});
          chk("sout", {31'd0, sout}, {31'd0, e.s});
          chk("done", {31'd0, done}, {31'd0, e.dn});
          chk("busy", {31'd0, busy}, {31'd0, ~e.dn});
        end
      end
    end
  end
  // issued at posedge+1; returns at posedge+1 in the cycle after the op's last edge
  task automatic run_op(input logic [2:0] m, input int n, input logic [W-1:0] dd,
                        input int sinv, input int ab_k, input int ab_kind);
    logic [W:0] r;
    start = 1'b1; mode = m; amount = n[AW-1:0]; d = dd; sin = 1'($urandom);
    if (m == LOAD) m_q = dd;
    if (m inside {HOLD, LOAD, RSVD} || n == 0) begin
      sb.push_back('{m_q, m_sout, 1'b1});
      @(posedge clk) #1;
      start = 1'b0;
      return;
    end
    sb.push_back('{m_q, m_sout, 1'b0});
    @(posedge clk) #1;
    for (int k = 1; k <= n; k++) begin
      start = 1'($urandom); mode = 3'($urandom); amount = AW'($urandom); d = W'($urandom);
      sin = sinv < 0 ? 1'($urandom) : sinv[0];
      if (k == ab_k && ab_kind == 1) begin
        set = 1'b1; start = 1'b1; mode = LOAD;
        @(posedge clk) #1;
        set = 1'b0; start = 1'b0;
        sb.delete();
        m_q = '1; m_sout = 1'b0;
        chk("set_q", {24'd0, q}, 32'hFF);
        chk("set_busy", {31'd0, busy}, 32'd0);
        chk("set_done", {31'd0, done}, 32'd0);
        chk("set_sout", {31'd0, sout}, 32'd0);
        return;
      end
      if (k == ab_k && ab_kind == 2) begin
        start = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("areset_q", {24'd0, q}, 32'd0);
        chk("areset_qbar", {24'd0, qbar}, 32'hFF);
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_done", {31'd0, done}, 32'd0);
        chk("areset_sout", {31'd0, sout}, 32'd0);
        sb.delete();
        m_q = '0; m_sout = 1'b0;
        @(posedge clk) #1;
        reset = 1'b0;
        return;
      end
      r = model_step(m, m_q, sin);
      m_q = r[W-1:0]; m_sout = r[W];
      sb.push_back('{m_q, m_sout, k == n});
      @(posedge clk) #1;
    end
    start = 1'b0;
  endtask
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk) #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    #2 reset = 1'b1;
    #10;
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_qbar", {24'd0, qbar}, 32'hFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sout", {31'd0, sout}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;
    run_op(LOAD, 0, 8'hA5, 0, 0, 0);
    idle(1);
    run_op(SHL, 3, 8'h00, 1, 0, 0);
    idle(2);
    run_op(LOAD, 0, 8'h81, 0, 0, 0);
    run_op(ROTR, 9, 8'h00, -1, 0, 0);
    run_op(SHL, 0, 8'h00, 1, 0, 0);
    idle(1);
    run_op(LOAD, 0, 8'h90, 0, 0, 0);
    run_op(ASR, 2, 8'h00, 0, 0, 0);
    idle(1);
    run_op(LOAD, 0, 8'h3C, 0, 0, 0);
    run_op(SHL, 5, 8'h00, -1, 2, 1);
    idle(1);
    run_op(LOAD, 0, 8'h5A, 0, 0, 0);
    run_op(SHR, 5, 8'h00, -1, 3, 2);
    run_op(LOAD, 0, 8'h12, 0, 0, 0);
    run_op(LOAD, 0, 8'hE7, 0, 0, 0);
    run_op(RSVD, 4, 8'h00, 0, 0, 0);
    run_op(HOLD, 6, 8'hFF, 0, 0, 0);
    run_op(SHR, 12, 8'h00, -1, 0, 0);
    run_op(ROTL, 15, 8'h00, -1, 0, 0);
    for (int i = 0; i < 150; i++) begin
      logic [2:0] m;
      int n, ak, akind;
      m = 3'($urandom_range(0, 7));
      n = $urandom_range(0, 3) == 0 ? $urandom_range(8, 15) : $urandom_range(0, 7);
      akind = $urandom_range(0, 19) == 0 ? $urandom_range(1, 2) : 0;
      ak = $urandom_range(1, n > 0 ? n : 1);
      run_op(m, n, W'($urandom), -1, ak, akind);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal register, successor to the single-bit set/reset D flip-flop.
- WIDTH-bit register with complementary outputs (q, qbar), synchronous preset, parallel load and multi-cycle shift/rotate operations.
- Operations are launched by a start/busy/done handshake and run one bit per clock.
- Used as a general register and serialiser/deserialiser in datapath blocks.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, $clog2(WIDTH)+1, width of the shift-amount port

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
set  input  1  synchronous preset, active-high
start  input  1  launch operation (sampled when not busy)
mode  input  3  operation select, latched at start
amount  input  AMT_W  number of single-bit steps, latched at start
d  input  WIDTH  parallel load data
sin  input  1  serial input, sampled on every shift step
q  output  WIDTH  register contents
qbar  output  WIDTH  ~q (combinational)
sout  output  1  last bit shifted/rotated out (registered)
busy  output  1  high while steps remain
done  output  1  one-cycle completion pulse

Behaviour:
- Mode encoding:
  - 000 HOLD
  - 001 LOAD
  - 010 SHL (sin enters the LSB)
  - 011 SHR (sin enters the MSB)
  - 100 ROTL
  - 101 ROTR
  - 110 ASR (MSB replicated; sin ignored)
  - 111 reserved, behaves as HOLD.
- Reset (async, highest priority): q=0, qbar=all ones, sout=0, busy=0, done=0, state IDLE, step counter 0. Reset mid-operation aborts immediately; no done pulse.
- set (sync, priority over everything except reset): q<=all ones, sout<=0, state->IDLE, busy=0, done=0. The operation in flight is abandoned; start on the same edge is ignored.
- FSM states are IDLE, RUN and DONE. start is accepted in IDLE or DONE, which allows back-to-back operations.
- Start edge (E0): latch mode and amount.
  - LOAD: q<=d at E0, then ->DONE.
  - HOLD/reserved, or amount==0: q unchanged, ->DONE.
  - Otherwise: ->RUN with counter=amount. busy=1 from the cycle after E0.
- RUN:
  - Each edge performs exactly one step and decrements the counter.
  - sout<=the bit leaving the register: MSB for SHL/ROTL, LSB for SHR/ROTR/ASR.
  - At the edge performing step N, go ->DONE. Final q is visible after edge E0+N; busy drops in the same cycle.
- DONE: done=1 for exactly one cycle. Go ->IDLE next edge, or ->RUN/DONE if start is asserted.
- Total latency: start to done = N+1 cycles for shifts (N = amount); 1 cycle for LOAD/HOLD/zero amount.
- start while busy=1 is ignored; mode, amount and d changes during RUN have no effect. sin is sampled live on each step.
- Amounts >= WIDTH are legal and are executed as literal steps: SHL/SHR fully flush with sin, ASR saturates to sign fill, rotations wrap modulo WIDTH.
- busy and done are never high together.

Decomposition:
- Package shift_reg_pkg holds the mode localparams (MODE_HOLD..MODE_RSVD) and the state encoding (ST_IDLE, ST_RUN, ST_DONE).
- One combinational sub-module, shift_step: inputs q, mode, sin; outputs next q and out-bit. It is reused by RUN and is unit-testable alone.
- Top level holds the FSM, the counter and the registers.

Test Plan:
1. WIDTH=8, LOAD d=0xA5 -> q=0xA5, qbar=0x5A after E0; done high one cycle later; busy never high.
2. From 0xA5: SHL amount=3, sin=1 -> q=0x4B/sout=1, then 0x97/sout=0, then 0x2F/sout=1. busy high 3 cycles, then a done pulse.
3. From 0x81: ROTR amount=9 -> q=0xC0 after 9 steps; busy high 9 cycles. amount=0 -> done after 1 cycle, q unchanged.
4. From 0x90: ASR amount=2, sin=0 -> 0xC8, then 0xE4; sout=0 both steps.
5. Assert set during step 2 of a 5-step SHL -> q=0xFF next edge, busy=0, no done. A start pulse asserted during the busy phase is ignored (q unaffected).
6. Assert reset asynchronously mid-RUN, between edges -> q=0x00, qbar=0xFF, busy=0 immediately. After release, a back-to-back LOAD in the DONE cycle is accepted.
